spr_burst: RTL and testbench
============================

SPR_BURST -- requirements
Module: spr_burst

Interface
REQ-001: Parameter DATA_W, default 8, SHALL set the memory word width and the command payload width.
REQ-002: Parameter ADDR_W, default 8, SHALL set the address width; DATA_W >= ADDR_W is required.
REQ-003: Parameter MEM_DEPTH, default 2**ADDR_W, SHALL set the number of words.
REQ-004: The block SHALL have one clock; reset is synchronous and active-high.
REQ-005: clk  in  1  rising-edge clock.
REQ-006: rst  in  1  synchronous active-high reset.
REQ-007: din  in  DATA_W+2  command word: [DATA_W+1:DATA_W] = opcode, [DATA_W-1:0] = payload.
REQ-008: rx_valid  in  1  din is valid this cycle.
REQ-009: cmd_ready  out  1  block accepts a command this cycle.
REQ-010: dout  out  DATA_W  read data.
REQ-011: tx_valid  out  1  dout is valid.
REQ-012: tx_ready  in  1  consumer takes dout this cycle.
REQ-013: par_err  out  1  parity error flag for the current dout.

Function
REQ-014: A command SHALL be accepted only on an edge where rx_valid and cmd_ready are both 1; rx_valid with cmd_ready=0 SHALL be ignored.
REQ-015: Opcode 00 (write address) SHALL load write_addr <= payload[ADDR_W-1:0]; upper payload bits ignored.
REQ-016: Opcode 01 (write data) SHALL write mem[write_addr] <= payload, then write_addr <= write_addr+1 (mod MEM_DEPTH).
REQ-017: Opcode 10 (read address) SHALL load read_addr <= payload[ADDR_W-1:0].
REQ-018: Opcode 11 (read burst) SHALL start a burst of payload+1 words (1..2**DATA_W) from read_addr.
REQ-019: FSM states SHALL be IDLE, FETCH, SEND; cmd_ready = (state==IDLE).
REQ-020: IDLE -> FETCH on accepting opcode 11, latching remaining <= payload.
REQ-021: FETCH SHALL, on the next edge, set dout <= mem[read_addr], tx_valid <= 1, read_addr <= read_addr+1, state <= SEND.
REQ-022: In SEND, when tx_ready=0, dout and tx_valid SHALL hold.
REQ-023: In SEND, when tx_ready=1 and remaining!=0, the block SHALL load the next word on the same edge (tx_valid stays 1, remaining-1, read_addr+1): one word per cycle at full throughput.
REQ-024: In SEND, when tx_ready=1 and remaining==0, tx_valid <= 0 and state <= IDLE; dout holds its last value.
REQ-025: read_addr and write_addr SHALL wrap from MEM_DEPTH-1 to 0; for MEM_DEPTH < 2**ADDR_W, wrap SHALL occur at MEM_DEPTH-1 and out-of-range addresses SHALL be reduced modulo MEM_DEPTH.
REQ-026: The memory SHALL be single-port: at most one read or write per cycle, which the FSM guarantees by construction.
REQ-027: First-word latency SHALL be 2 edges from command acceptance to tx_valid=1.

Reset
REQ-028: When rst=1, on the next edge: state=IDLE, write_addr=0, read_addr=0, remaining=0, dout=0, tx_valid=0, par_err=0.
REQ-029: Reset mid-burst SHALL abort the burst immediately; memory contents SHALL NOT be reset.

Configuration
REQ-030: With SPR_PARITY_EN defined, each word SHALL store an extra even-parity bit computed on write; par_err SHALL be registered alongside dout, equal to the parity mismatch of that word.
REQ-031: Without SPR_PARITY_EN, memory SHALL be DATA_W wide and par_err SHALL be tied to 0.

Structure
REQ-032: Package spr_pkg SHALL hold the opcode enum (OP_WADDR, OP_WDATA, OP_RADDR, OP_RBURST) and the FSM state enum.
REQ-033: Sub-module spr_mem SHALL hold the storage array: one port, synchronous read, write enable, parametrised width (DATA_W or DATA_W+1).

Verification
REQ-034: Reset, then {00,0x10}, {01,0xA5}, {01,0x5A} -> mem[0x10]=0xA5, mem[0x11]=0x5A, write_addr=0x12.
REQ-035: {10,0x10}, {11,0x01}, tx_ready=1 held -> tx_valid high 2 consecutive cycles, dout 0xA5 then 0x5A, cmd_ready low until the burst completes.
REQ-036: Burst of 3 with tx_ready toggling 1,0,0,1,1 -> each word held while stalled, no word lost or duplicated, tx_valid low after the third handshake.
REQ-037: {00,0xFF}, {01,0x11}, {01,0x22}, then a read burst from 0xFF -> 0x11 then 0x22 (address wrap to 0x00).
REQ-038: rx_valid pulsed with {00,0x33} during SEND -> ignored, write_addr unchanged.
REQ-039: rst=1 during a burst -> next edge tx_valid=0, dout=0, cmd_ready=1; previously written data still reads back correctly; with SPR_PARITY_EN, a forced parity-bit flip -> par_err=1 with that word.

Source files
------------

// File: rtl/spr_pkg.sv
// Shared types for the spr_burst scratchpad: command opcodes and FSM states.
package spr_pkg;

  localparam int OPCODE_W = 2;

  typedef enum logic [1:0] {
    OP_WADDR  = 2'b00,
    OP_WDATA  = 2'b01,
    OP_RADDR  = 2'b10,
    OP_RBURST = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    FETCH = 2'b01,
    SEND  = 2'b10
  } state_e;

endpackage

// File: rtl/spr_mem.sv
// Single-port storage array for spr_burst: one access per cycle, synchronous
// read with a held read register, so the read word stays put while no read
// is issued. The registered rpar is the XOR of the whole word read out.
module spr_mem #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic [WIDTH-1:0]  rdata,
  output logic              rpar
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rdata_r;
  logic             rpar_r;

  // Storage write; contents are intentionally not cleared by reset.
  always_ff @(posedge clk) begin
    if (en && we) begin
      mem_r[addr] <= wdata;
    end
  end

  // Synchronous read register, holds its value between reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r <= {WIDTH{1'b0}};
      rpar_r  <= 1'b0;
    end else if (en && !we) begin
      rdata_r <= mem_r[addr];
      rpar_r  <= ^mem_r[addr];
    end else begin
      rdata_r <= rdata_r;
      rpar_r  <= rpar_r;
    end
  end

  assign rdata = rdata_r;
  assign rpar  = rpar_r;

endmodule

// File: rtl/spr_burst.sv
// Scratchpad with a command port (write address / write data / read address /
// read burst) and a valid/ready burst read port streaming one word per cycle.
// Optional feature: define SPR_PARITY_EN to store an even-parity bit with each
// word and flag mismatches on par_err; otherwise par_err is tied low.
module spr_burst
  import spr_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 2**ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W+1:0]   din,
  input  logic                rx_valid,
  output logic                cmd_ready,
  output logic [DATA_W-1:0]   dout,
  output logic                tx_valid,
  input  logic                tx_ready,
  output logic                par_err
);

`ifdef SPR_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  state_e              state_r;
  logic [ADDR_W-1:0]   write_addr_r;
  logic [ADDR_W-1:0]   read_addr_r;
  logic [DATA_W-1:0]   remaining_r;
  logic                tx_valid_r;
  logic                cmd_ready_r;

  logic                accept_s;
  op_e                 opcode_s;
  logic [DATA_W-1:0]   payload_s;
  logic                mem_en_s;
  logic                mem_we_s;
  logic [ADDR_W-1:0]   mem_addr_s;
  logic [MEM_W-1:0]    mem_wdata_s;
  logic [MEM_W-1:0]    mem_rdata_s;
  logic                mem_rpar_s;
  logic                unused_s;

  // Loaded addresses are reduced into the implemented depth.
  function automatic logic [ADDR_W-1:0] mod_addr(input logic [ADDR_W-1:0] a);
    return ADDR_W'(32'(a) % 32'(MEM_DEPTH));
  endfunction

  // Increment with wrap at MEM_DEPTH-1.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(MEM_DEPTH - 1)) ? {ADDR_W{1'b0}} : a + {{(ADDR_W-1){1'b0}}, 1'b1};
  endfunction

`ifdef SPR_PARITY_EN
  // Even parity: stored bit makes the XOR of the whole stored word zero.
  function automatic logic even_par(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction
`endif

  assign opcode_s  = op_e'(din[DATA_W+1:DATA_W]);
  assign payload_s = din[DATA_W-1:0];
  assign accept_s  = rx_valid && cmd_ready_r;

  // Memory port arbitration: writes only in IDLE, reads only in FETCH/SEND.
  always_comb begin
    mem_we_s   = 1'b0;
    mem_en_s   = 1'b0;
    mem_addr_s = read_addr_r;
    if (!rst && accept_s && (opcode_s == OP_WDATA)) begin
      mem_we_s   = 1'b1;
      mem_en_s   = 1'b1;
      mem_addr_s = write_addr_r;
    end else if (!rst && ((state_r == FETCH) ||
                          ((state_r == SEND) && tx_ready && (remaining_r != {DATA_W{1'b0}})))) begin
      mem_en_s   = 1'b1;
      mem_addr_s = read_addr_r;
    end else begin
      mem_we_s   = 1'b0;
      mem_en_s   = 1'b0;
    end
  end

`ifdef SPR_PARITY_EN
  assign mem_wdata_s = {even_par(payload_s), payload_s};
  assign par_err     = mem_rpar_s;
  assign unused_s    = mem_rdata_s[DATA_W];
`else
  assign mem_wdata_s = payload_s;
  assign par_err     = 1'b0;
  assign unused_s    = mem_rpar_s;
`endif

  spr_mem #(
    .WIDTH  (MEM_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (MEM_DEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .en    (mem_en_s),
    .we    (mem_we_s),
    .addr  (mem_addr_s),
    .wdata (mem_wdata_s),
    .rdata (mem_rdata_s),
    .rpar  (mem_rpar_s)
  );

  // Command decode and burst FSM with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      write_addr_r <= {ADDR_W{1'b0}};
      read_addr_r  <= {ADDR_W{1'b0}};
      remaining_r  <= {DATA_W{1'b0}};
      tx_valid_r   <= 1'b0;
      cmd_ready_r  <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            case (opcode_s)
              OP_WADDR:  write_addr_r <= mod_addr(payload_s[ADDR_W-1:0]);
              OP_WDATA:  write_addr_r <= next_addr(write_addr_r);
              OP_RADDR:  read_addr_r  <= mod_addr(payload_s[ADDR_W-1:0]);
              OP_RBURST: begin
                remaining_r <= payload_s;
                state_r     <= FETCH;
                cmd_ready_r <= 1'b0;
              end
              default:   state_r <= IDLE;
            endcase
          end
        end
        FETCH: begin
          tx_valid_r  <= 1'b1;
          read_addr_r <= next_addr(read_addr_r);
          state_r     <= SEND;
        end
        SEND: begin
          if (tx_ready) begin
            if (remaining_r != {DATA_W{1'b0}}) begin
              remaining_r <= remaining_r - {{(DATA_W-1){1'b0}}, 1'b1};
              read_addr_r <= next_addr(read_addr_r);
            end else begin
              tx_valid_r  <= 1'b0;
              state_r     <= IDLE;
              cmd_ready_r <= 1'b1;
            end
          end
        end
        default: begin
          state_r     <= IDLE;
          tx_valid_r  <= 1'b0;
          cmd_ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign dout      = mem_rdata_s[DATA_W-1:0];
  assign tx_valid  = tx_valid_r;
  assign cmd_ready = cmd_ready_r;

endmodule

// File: tb/tb_spr_burst.sv
// Directed self-checking bench for spr_burst (DATA_W=8, ADDR_W=8).
module tb_spr_burst;

  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic [DW+1:0] din;
  logic          rx_valid;
  logic          cmd_ready;
  logic [DW-1:0] dout;
  logic          tx_valid;
  logic          tx_ready;
  logic          par_err;

  int n_tests;
  int n_fail;

  spr_burst #(.DATA_W(8), .ADDR_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .rx_valid  (rx_valid),
    .cmd_ready (cmd_ready),
    .dout      (dout),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .par_err   (par_err)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op, input logic [7:0] pl);
    din      = {op, pl};
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask

  // Stall pattern for the 3-word burst and the expected outputs after each edge.
  logic       stall_rdy [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
  logic       exp_vld   [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [7:0] exp_dat   [5] = '{8'h5A, 8'h5A, 8'h5A, 8'hC3, 8'hC3};

  // Directed sequence.
  initial begin
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    din      = '0;
    rx_valid = 1'b0;
    tx_ready = 1'b0;
    tick();
    tick();
    check_eq("rst_tx_valid", 32'(tx_valid), 32'h0);
    check_eq("rst_dout", 32'(dout), 32'h0);
    check_eq("rst_cmd_ready", 32'(cmd_ready), 32'h1);
    check_eq("rst_par_err", 32'(par_err), 32'h0);
    rst = 1'b0;
    tick();

    // Writes with auto-increment.
    send_cmd(2'b00, 8'h10);
    send_cmd(2'b01, 8'hA5);
    send_cmd(2'b01, 8'h5A);
    check_eq("mem10", 32'(dut.u_mem.mem_r[16][7:0]), 32'hA5);
    check_eq("mem11", 32'(dut.u_mem.mem_r[17][7:0]), 32'h5A);
    check_eq("waddr12", 32'(dut.write_addr_r), 32'h12);

    // Two-word burst at full throughput.
    tx_ready = 1'b1;
    send_cmd(2'b10, 8'h10);
    send_cmd(2'b11, 8'h01);
    check_eq("b2_fetch_vld", 32'(tx_valid), 32'h0);
    check_eq("b2_fetch_rdy", 32'(cmd_ready), 32'h0);
    tick();
    check_eq("b2_w0_vld", 32'(tx_valid), 32'h1);
    check_eq("b2_w0_dat", 32'(dout), 32'hA5);
    check_eq("b2_w0_rdy", 32'(cmd_ready), 32'h0);
    check_eq("b2_w0_perr", 32'(par_err), 32'h0);
    tick();
    check_eq("b2_w1_vld", 32'(tx_valid), 32'h1);
    check_eq("b2_w1_dat", 32'(dout), 32'h5A);
    check_eq("b2_w1_rdy", 32'(cmd_ready), 32'h0);
    tick();
    check_eq("b2_end_vld", 32'(tx_valid), 32'h0);
    check_eq("b2_end_rdy", 32'(cmd_ready), 32'h1);
    check_eq("b2_end_dat", 32'(dout), 32'h5A);

    // Three-word burst with back-pressure.
    tx_ready = 1'b0;
    send_cmd(2'b01, 8'hC3);
    send_cmd(2'b10, 8'h10);
    send_cmd(2'b11, 8'h02);
    tick();
    check_eq("b3_w0_vld", 32'(tx_valid), 32'h1);
    check_eq("b3_w0_dat", 32'(dout), 32'hA5);
    for (int i = 0; i < 5; i++) begin
      tx_ready = stall_rdy[i];
      tick();
      check_eq($sformatf("b3_vld%0d", i), 32'(tx_valid), 32'(exp_vld[i]));
      check_eq($sformatf("b3_dat%0d", i), 32'(dout), 32'(exp_dat[i]));
    end
    check_eq("b3_end_rdy", 32'(cmd_ready), 32'h1);

    // Address wrap from 0xFF to 0x00.
    send_cmd(2'b00, 8'hFF);
    send_cmd(2'b01, 8'h11);
    send_cmd(2'b01, 8'h22);
    check_eq("wrap_waddr", 32'(dut.write_addr_r), 32'h01);
    tx_ready = 1'b1;
    send_cmd(2'b10, 8'hFF);
    send_cmd(2'b11, 8'h01);
    tick();
    check_eq("wrap_w0", 32'(dout), 32'h11);
    tick();
    check_eq("wrap_w1", 32'(dout), 32'h22);
    check_eq("wrap_w1_vld", 32'(tx_valid), 32'h1);
    tick();
    check_eq("wrap_end_vld", 32'(tx_valid), 32'h0);
    check_eq("wrap_raddr", 32'(dut.read_addr_r), 32'h01);

    // Command during SEND is ignored.
    tx_ready = 1'b0;
    send_cmd(2'b10, 8'h10);
    send_cmd(2'b11, 8'h01);
    tick();
    din      = {2'b00, 8'h33};
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    check_eq("ign_waddr", 32'(dut.write_addr_r), 32'h01);
    check_eq("ign_vld", 32'(tx_valid), 32'h1);
    check_eq("ign_dat", 32'(dout), 32'hA5);

    // Reset mid-burst aborts it; memory survives.
    rst = 1'b1;
    tick();
    check_eq("mid_rst_vld", 32'(tx_valid), 32'h0);
    check_eq("mid_rst_dat", 32'(dout), 32'h0);
    check_eq("mid_rst_rdy", 32'(cmd_ready), 32'h1);
    rst      = 1'b0;
    tx_ready = 1'b1;
    send_cmd(2'b10, 8'h11);
    send_cmd(2'b11, 8'h00);
    tick();
    check_eq("post_rst_dat", 32'(dout), 32'h5A);
    check_eq("post_rst_vld", 32'(tx_valid), 32'h1);
    tick();
    check_eq("post_rst_end", 32'(tx_valid), 32'h0);

`ifdef SPR_PARITY_EN
    // Corrupt the stored parity bit of 0x10 and read it back.
    dut.u_mem.mem_r[16][8] = ~dut.u_mem.mem_r[16][8];
    send_cmd(2'b10, 8'h10);
    send_cmd(2'b11, 8'h00);
    tick();
    check_eq("par_dat", 32'(dout), 32'hA5);
    check_eq("par_err", 32'(par_err), 32'h1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
